wdt_pat_sequencer: RTL and testbench
====================================

# wdt_pat_sequencer

Bus-master controller that configures and services the TinyQV watchdog peripheral on behalf of up to `NUM_SRC` software/hardware heartbeat sources. On `start` it writes WINDOW_START, WINDOW_CLOSE and ENABLE to the watchdog. It then issues a PAT write only after every masked source has checked in and the window is open. It also mirrors the watchdog timer locally, so a missed window or watchdog expiry is reported as a sticky fault.

## Interface
- `NUM_SRC`, 4, number of heartbeat sources (1..8)
- `CNT_W`, 32, width of the local window counter; matches the watchdog timer width
- `clk`  in  1  project clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  one-cycle request to (re)configure and arm; honoured only in IDLE or FAULT
- `cfg_window_start`  in  32  window-open threshold, sampled when `start` is accepted
- `cfg_window_close`  in  32  window-close threshold, sampled when `start` is accepted
- `src_mask`  in  NUM_SRC  sources that must check in before a pat; sampled continuously
- `hb_req`  in  NUM_SRC  per-source heartbeat, active-high pulse or level
- `wdt_expired`  in  1  watchdog `user_interrupt`
- `wdt_address`  out  6  watchdog register address
- `wdt_data`  out  32  watchdog write data
- `wdt_write_n`  out  2  `2'b11` idle, `2'b10` 32-bit write
- `armed`  out  1  high in ARMED and PAT
- `fault`  out  1  high in FAULT
- `fault_cause`  out  2  `01` missed window, `10` watchdog expired, `11` bad config, `00` none
- `pending`  out  NUM_SRC  sticky check-in flags
- `pat_count`  out  16  number of pats issued since the last accepted `start`; wraps

## Operation

**States**

The FSM has seven states: IDLE, CFG_START, CFG_CLOSE, CFG_EN, ARMED, PAT, FAULT.

**Transitions**
- IDLE or FAULT with `start`:
  - `cfg_window_close <= cfg_window_start` → FAULT, cause `11`.
  - Otherwise → CFG_START. Latch both windows, clear `pending`, `pat_count` and `fault_cause`.
- CFG_START: write addr 1, data = latched window_start. Next state CFG_CLOSE.
- CFG_CLOSE: write addr 2, data = latched window_close. Next state CFG_EN.
- CFG_EN: write addr 0, data 1. Next state ARMED.
- ARMED is evaluated in this priority order:
  1. `wdt_expired` → FAULT, cause `10`.
  2. `cnt > win_close` → FAULT, cause `01`.
  3. `src_mask != 0`, `(pending & src_mask) == src_mask` and `cnt > win_start` → PAT.
  4. Otherwise stay in ARMED.
- PAT: write addr 3, data 1. Increment `pat_count`. Next state ARMED.
- FAULT: sticky. Only `start` leaves it.

**Local counter `cnt`**
- Cleared to 0 in CFG_EN and in PAT.
- In ARMED, incremented by 1 each cycle, saturating at all-ones.
- Held in all other states.

**Check-in flags `pending`**
- `pending[i]` is set by `hb_req[i]` in any state except IDLE and FAULT.
- `pending` is cleared in PAT.
- A `hb_req` in the same cycle as PAT is retained, so the set wins over the clear for that bit.
- Bits outside `src_mask` may set but are ignored in the pat condition.

**Other rules**
- `src_mask == 0`: no pat is ever issued, so the block eventually faults with cause `01`.
- `start` in CFG_*, ARMED or PAT is ignored.
- The block never writes to the watchdog in IDLE or FAULT.

## Timing
- All outputs are registered (Moore).
- The bus write is visible in the cycle the FSM is in the write state.
- Each write holds `wdt_write_n = 2'b10` for exactly one cycle. The watchdog always has `data_ready = 1`, so there is no wait state.
- When not writing: `wdt_write_n = 2'b11`, `wdt_address = 0`, `wdt_data = 0`.
- Latencies:
  - `start` accepted at edge N: CFG_START writes in cycle N+1, CFG_CLOSE in N+2, CFG_EN in N+3, and `armed` rises in N+4.
  - Pat condition true in ARMED in cycle M: PAT write in cycle M+1, `pending` = 0 (except same-cycle `hb_req`) and `pat_count` incremented in cycle M+2.
  - Fault condition in cycle M: `fault = 1` with its cause in cycle M+1.
- Reset values: state IDLE, `cnt` 0, `pending` 0, `pat_count` 0, `fault` 0, `fault_cause` 0, `armed` 0, `wdt_write_n` `2'b11`, `wdt_address` 0, `wdt_data` 0.
- Reset asserted mid-write: `wdt_write_n` returns to `2'b11` immediately (asynchronously), with no partial sequence resumed.

## Test plan
- **Config sequence:** reset, `start` with windows 10/40 → exactly three writes, (1, 10), (2, 40), (0, 1), on consecutive cycles; `armed` = 1 the following cycle.
- **Early heartbeats:** mask `4'b0011`, `hb_req` on sources 0 and 1 at `cnt` = 3 → no PAT until `cnt` = 11; single write (3, 1); `pat_count` = 1; `pending` = 0.
- **Missed window:** mask `4'b0001`, no heartbeats, windows 10/40 → `fault` = 1, cause `01` one cycle after `cnt` = 41; no further writes; `start` re-runs the config sequence.
- **Watchdog expiry:** force `wdt_expired` = 1 in ARMED → FAULT, cause `10` next cycle.
- **Simultaneous heartbeat and pat:** `hb_req[2]` asserted in the PAT cycle → after PAT, `pending` = `4'b0100`.
- **Bad config and reset:** `start` with windows 20/20 → cause `11`, no writes. Assert `rst_n` low during CFG_CLOSE → `wdt_write_n` = `2'b11` at once; state IDLE after release.

Source files
------------

// File: rtl/wdt_pat_sequencer.sv
// Configures the TinyQV watchdog, then pats it only after all masked heartbeat sources
// have checked in and the window is open. It mirrors the timer locally to flag missed windows.
module wdt_pat_sequencer #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        cfg_window_start,
    input  logic [31:0]        cfg_window_close,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic [NUM_SRC-1:0] hb_req,
    input  logic               wdt_expired,
    output logic [5:0]         wdt_address,
    output logic [31:0]        wdt_data,
    output logic [1:0]         wdt_write_n,
    output logic               armed,
    output logic               fault,
    output logic [1:0]         fault_cause,
    output logic [NUM_SRC-1:0] pending,
    output logic [15:0]        pat_count
);

    localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_START, S_CFG_CLOSE, S_CFG_EN, S_ARMED, S_PAT, S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        win_start_q, win_start_d;
    logic [31:0]        win_close_q, win_close_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [15:0]        pat_count_q, pat_count_d;
    logic [1:0]         cause_q, cause_d;
    logic [5:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         wr_n_q, wr_n_d;
    logic               armed_q, armed_d;
    logic               fault_q, fault_d;

    logic [NUM_SRC-1:0] hb_set;
    logic               past_close;
    logic               past_start;
    logic               all_in;

    assign past_close = CMP_W'(cnt_q) > CMP_W'(win_close_q);
    assign past_start = CMP_W'(cnt_q) > CMP_W'(win_start_q);
    assign all_in     = (src_mask != '0) && ((pending_q & src_mask) == src_mask);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_start_d = win_start_q;
        win_close_d = win_close_q;
        pat_count_d = pat_count_q;
        cause_d     = cause_q;

        hb_set = (state_q == S_IDLE || state_q == S_FAULT) ? '0 : hb_req;
        // A heartbeat arriving during the pat cycle survives the clear.
        pending_d = (state_q == S_PAT) ? hb_set : (pending_q | hb_set);

        case (state_q)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    if (cfg_window_close <= cfg_window_start) begin
                        state_d = S_FAULT;
                        cause_d = 2'b11;
                    end else begin
                        state_d     = S_CFG_START;
                        win_start_d = cfg_window_start;
                        win_close_d = cfg_window_close;
                        pending_d   = '0;
                        pat_count_d = '0;
                        cause_d     = 2'b00;
                    end
                end
            end
            S_CFG_START: state_d = S_CFG_CLOSE;
            S_CFG_CLOSE: state_d = S_CFG_EN;
            S_CFG_EN: begin
                state_d = S_ARMED;
                cnt_d   = '0;
            end
            S_ARMED: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (wdt_expired) begin
                    state_d = S_FAULT;
                    cause_d = 2'b10;
                end else if (past_close) begin
                    state_d = S_FAULT;
                    cause_d = 2'b01;
                end else if (all_in && past_start) begin
                    state_d = S_PAT;
                end
            end
            S_PAT: begin
                state_d     = S_ARMED;
                cnt_d       = '0;
                pat_count_d = pat_count_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they appear registered in the write state.
    always_comb begin
        wr_n_d  = 2'b11;
        addr_d  = 6'd0;
        data_d  = 32'd0;
        armed_d = (state_d == S_ARMED) || (state_d == S_PAT);
        fault_d = (state_d == S_FAULT);
        case (state_d)
            S_CFG_START: begin
                wr_n_d = 2'b10;
                addr_d = 6'd1;
                data_d = win_start_d;
            end
            S_CFG_CLOSE: begin
                wr_n_d = 2'b10;
                addr_d = 6'd2;
                data_d = win_close_d;
            end
            S_CFG_EN: begin
                wr_n_d = 2'b10;
                addr_d = 6'd0;
                data_d = 32'd1;
            end
            S_PAT: begin
                wr_n_d = 2'b10;
                addr_d = 6'd3;
                data_d = 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            win_start_q <= '0;
            win_close_q <= '0;
            pending_q   <= '0;
            pat_count_q <= '0;
            cause_q     <= 2'b00;
            addr_q      <= 6'd0;
            data_q      <= 32'd0;
            wr_n_q      <= 2'b11;
            armed_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_start_q <= win_start_d;
            win_close_q <= win_close_d;
            pending_q   <= pending_d;
            pat_count_q <= pat_count_d;
            cause_q     <= cause_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_n_q      <= wr_n_d;
            armed_q     <= armed_d;
            fault_q     <= fault_d;
        end
    end

    assign wdt_address = addr_q;
    assign wdt_data    = data_q;
    assign wdt_write_n = wr_n_q;
    assign armed       = armed_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign pending     = pending_q;
    assign pat_count   = pat_count_q;

endmodule

// File: tb/tb_wdt_pat_sequencer.sv
// Directed bench for wdt_pat_sequencer: a cycle-level behavioural model is checked every cycle,
// and literal expectations at key points pin the model itself.
module tb_wdt_pat_sequencer;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   cfg_ws = 32'd0;
    logic [31:0]   cfg_wc = 32'd0;
    logic [N-1:0]  src_mask = '0;
    logic [N-1:0]  hb_req = '0;
    logic          wdt_expired = 1'b0;
    logic [5:0]    wdt_address;
    logic [31:0]   wdt_data;
    logic [1:0]    wdt_write_n;
    logic          armed;
    logic          fault;
    logic [1:0]    fault_cause;
    logic [N-1:0]  pending;
    logic [15:0]   pat_count;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr0;

    wdt_pat_sequencer #(.NUM_SRC(N), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_window_start(cfg_ws), .cfg_window_close(cfg_wc),
        .src_mask(src_mask), .hb_req(hb_req), .wdt_expired(wdt_expired),
        .wdt_address(wdt_address), .wdt_data(wdt_data), .wdt_write_n(wdt_write_n),
        .armed(armed), .fault(fault), .fault_cause(fault_cause),
        .pending(pending), .pat_count(pat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode plus config step index, window values and plain counters.
    localparam int M_IDLE = 0, M_CFG = 1, M_ARMED = 2, M_PAT = 3, M_FAULT = 4;
    int           m_mode = M_IDLE;
    int           m_step = 0;
    longint       m_cnt = 0;
    longint       m_ws = 0, m_wc = 0;
    logic [N-1:0] m_pend = '0;
    int           m_pats = 0;
    int           m_cause = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_step = 0; m_cnt = 0; m_pend = '0; m_pats = 0; m_cause = 0;
        end else begin
            int           mode_now;
            logic [N-1:0] p_new;
            mode_now = m_mode;
            p_new = m_pend;
            if (mode_now != M_IDLE && mode_now != M_FAULT)
                p_new = ((mode_now == M_PAT) ? '0 : m_pend) | hb_req;
            case (mode_now)
                M_IDLE, M_FAULT: if (start) begin
                    if (cfg_wc <= cfg_ws) begin
                        m_mode = M_FAULT; m_cause = 3;
                    end else begin
                        m_mode = M_CFG; m_step = 0; m_ws = cfg_ws; m_wc = cfg_wc;
                        p_new = '0; m_pats = 0; m_cause = 0;
                    end
                end
                M_CFG: begin
                    if (m_step < 2) m_step++;
                    else begin m_mode = M_ARMED; m_cnt = 0; end
                end
                M_ARMED: begin
                    if (wdt_expired) begin m_mode = M_FAULT; m_cause = 2; end
                    else if (m_cnt > m_wc) begin m_mode = M_FAULT; m_cause = 1; end
                    else if (src_mask != 0 && (m_pend & src_mask) == src_mask && m_cnt > m_ws)
                        m_mode = M_PAT;
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                end
                M_PAT: begin
                    m_pats = (m_pats + 1) % 65536; m_cnt = 0; m_mode = M_ARMED;
                end
                default: ;
            endcase
            m_pend = p_new;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0]  e_wn;
            logic [5:0]  e_a;
            logic [31:0] e_d;
            e_wn = 2'b11; e_a = 0; e_d = 0;
            if (m_mode == M_CFG) begin
                e_wn = 2'b10;
                case (m_step)
                    0: begin e_a = 1; e_d = 32'(m_ws); end
                    1: begin e_a = 2; e_d = 32'(m_wc); end
                    default: begin e_a = 0; e_d = 1; end
                endcase
            end else if (m_mode == M_PAT) begin
                e_wn = 2'b10; e_a = 3; e_d = 1;
            end
            chk("write_n", wdt_write_n, e_wn);
            chk("address", wdt_address, e_a);
            chk("data", wdt_data, e_d);
            chk("armed", armed, (m_mode == M_ARMED || m_mode == M_PAT) ? 1 : 0);
            chk("fault", fault, (m_mode == M_FAULT) ? 1 : 0);
            chk("fault_cause", fault_cause, m_cause);
            chk("pending", pending, m_pend);
            chk("pat_count", pat_count, m_pats);
            if (wdt_write_n == 2'b10) wr_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first write cycle (CFG_START) when the start is accepted.
    task automatic do_start(input logic [31:0] ws, input logic [31:0] wc);
        cfg_ws = ws; cfg_wc = wc; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst_write_n", wdt_write_n, 2'b11);
        chk("rst_armed", armed, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pat_count", pat_count, 0);
        #8 rst_n = 1'b1;
        step(2);

        // Config sequence plus early heartbeats, mask 0011
        src_mask = 4'b0011;
        do_start(32'd10, 32'd40);
        $display("config: start 10/40 accepted");
        chk("cfg1_wn", wdt_write_n, 2'b10); chk("cfg1_addr", wdt_address, 1); chk("cfg1_data", wdt_data, 10);
        step(1);
        chk("cfg2_addr", wdt_address, 2); chk("cfg2_data", wdt_data, 40);
        step(1);
        chk("cfg3_addr", wdt_address, 0); chk("cfg3_data", wdt_data, 1);
        step(1);
        chk("cfg_armed", armed, 1); chk("cfg_idle_bus", wdt_write_n, 2'b11);
        step(3);
        hb_req = 4'b0011;
        step(1);
        hb_req = '0;
        wr0 = wr_cnt;
        step(20);
        $display("early hb: pat_count=%0d pending=%b", pat_count, pending);
        chk("early_pat_count", pat_count, 1);
        chk("early_pending", pending, 0);
        chk("early_writes", wr_cnt - wr0, 1);
        step(60);
        chk("early_then_miss_cause", fault_cause, 2'b01);

        // Missed window, mask 0001, no heartbeats
        src_mask = 4'b0001;
        wr0 = wr_cnt;
        do_start(32'd10, 32'd40);
        step(60);
        $display("missed window: fault=%0d cause=%b", fault, fault_cause);
        chk("miss_fault", fault, 1);
        chk("miss_cause", fault_cause, 2'b01);
        chk("miss_writes", wr_cnt - wr0, 3);

        // Heartbeat coincident with the pat write
        do_start(32'd10, 32'd40);
        step(3);
        hb_req = 4'b0001;
        step(1);
        hb_req = '0;
        step(11);
        hb_req = 4'b0100;
        chk("pat_wn", wdt_write_n, 2'b10); chk("pat_addr", wdt_address, 3);
        step(1);
        hb_req = '0;
        $display("hb in pat: pending=%b pat_count=%0d", pending, pat_count);
        chk("same_cycle_pending", pending, 4'b0100);
        chk("same_cycle_pat_count", pat_count, 1);

        // Watchdog expiry while armed
        wdt_expired = 1'b1;
        step(1);
        wdt_expired = 1'b0;
        wr0 = wr_cnt;
        $display("expiry: fault=%0d cause=%b", fault, fault_cause);
        chk("exp_fault", fault, 1);
        chk("exp_cause", fault_cause, 2'b10);
        step(5);
        chk("exp_no_writes", wr_cnt - wr0, 0);

        // Bad configuration
        wr0 = wr_cnt;
        do_start(32'd20, 32'd20);
        $display("bad cfg: fault=%0d cause=%b", fault, fault_cause);
        chk("bad_fault", fault, 1);
        chk("bad_cause", fault_cause, 2'b11);
        step(5);
        chk("bad_no_writes", wr_cnt - wr0, 0);

        // Reset during CFG_CLOSE
        do_start(32'd10, 32'd40);
        step(1);
        chk("mid_addr", wdt_address, 2);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-write: write_n=%b", wdt_write_n);
        chk("mid_rst_write_n", wdt_write_n, 2'b11);
        chk("mid_rst_data", wdt_data, 0);
        #10 rst_n = 1'b1;
        step(1);
        chk("post_rst_armed", armed, 0);
        chk("post_rst_write_n", wdt_write_n, 2'b11);
        chk("post_rst_fault", fault, 0);
        step(3);
        chk("post_rst_still_idle", wdt_write_n, 2'b11);

        do_start(32'd5, 32'd9);
        step(3);
        $display("rearm after reset: armed=%0d", armed);
        chk("rearm_armed", armed, 1);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
